fifo_flags: RTL and testbench

- Parametrised synchronous FIFO; next generation of the UART-side byte FIFO.
- Generalised in data width and depth.
- Adds: first-word-fall-through read data, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags with software clear.
- Sits between the UART rx/tx engines and the game-logic/host interface; one clock domain.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_flags_if.sv | 33 +++
 rtl/fifo_ctrl.sv | 103 ++++++++++
 rtl/fifo_flags.sv | 58 +++++
 tb/tb_fifo_flags.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the fifo_flags FIFO.
// Used by the interface, the control block and the top.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 2;

  function automatic int depth_of(input int addr_width);
    return 32'sd1 <<< addr_width;
  endfunction

  function automatic bit thresh_ok(input int addr_width, input int af_thresh, input int ae_thresh);
    int depth;
    depth = depth_of(addr_width);
    return (af_thresh >= 32'sd1) && (af_thresh <= depth) &&
           (ae_thresh >= 32'sd0) && (ae_thresh <= depth - 32'sd1);
  endfunction

endpackage

// File: rtl/fifo_flags_if.sv
// Producer/consumer-side signal bundle of fifo_flags.
// master drives the requests; slave is the FIFO.
interface fifo_flags_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  rd;
  logic                  wr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output rd, wr, w_data, clr_err,
    input  r_data, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  rd, wr, w_data, clr_err,
    output r_data, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag control for fifo_flags; flags decode only
// from the registered count so rd/wr never reach them combinationally.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic                  clr_err,
  output logic                  do_wr,
  output logic [ADDR_WIDTH-1:0] w_ptr,
  output logic [ADDR_WIDTH-1:0] r_ptr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(32'd1);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(depth_of(ADDR_WIDTH));
  localparam logic [CNT_W-1:0]      AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]      AE_C    = CNT_W'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  empty_s, full_s, do_wr_s, do_rd_s;

  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign full_s  = (count_q == DEPTH_C);

  // Accept logic, next pointers/count and sticky error flags.
  always_comb begin
    do_wr_s     = wr & (~full_s | rd);
    do_rd_s     = rd & ~empty_s;
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (do_wr_s) w_ptr_d = w_ptr_q + PTR_ONE;
    else         w_ptr_d = w_ptr_q;
    if (do_rd_s) r_ptr_d = r_ptr_q + PTR_ONE;
    else         r_ptr_d = r_ptr_q;

    case ({do_wr_s, do_rd_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A fresh error on the same edge as clr_err keeps the flag set.
    if (wr & ~do_wr_s)  overflow_d = 1'b1;
    else if (clr_err)   overflow_d = 1'b0;
    else                overflow_d = overflow_q;

    if (rd & empty_s)   underflow_d = 1'b1;
    else if (clr_err)   underflow_d = 1'b0;
    else                underflow_d = underflow_q;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q     <= {ADDR_WIDTH{1'b0}};
      r_ptr_q     <= {ADDR_WIDTH{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign do_wr        = do_wr_s;
  assign w_ptr        = w_ptr_q;
  assign r_ptr        = r_ptr_q;
  assign count        = count_q;
  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_empty = (count_q <= AE_C);
  assign almost_full  = (count_q >= AF_C);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: rtl/fifo_flags.sv
// Synchronous first-word-fall-through FIFO with occupancy, threshold flags
// and sticky error flags; storage and read mux here, control in fifo_ctrl.
module fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input logic         clk,
  input logic         reset,
  fifo_flags_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  if (!thresh_ok(ADDR_WIDTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("fifo_flags: AF_THRESH/AE_THRESH outside legal range");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_wr_s;
  logic [ADDR_WIDTH-1:0] w_ptr_s;
  logic [ADDR_WIDTH-1:0] r_ptr_s;

  fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_THRESH  (AF_THRESH),
    .AE_THRESH  (AE_THRESH)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .rd           (bus.rd),
    .wr           (bus.wr),
    .clr_err      (bus.clr_err),
    .do_wr        (do_wr_s),
    .w_ptr        (w_ptr_s),
    .r_ptr        (r_ptr_s),
    .count        (bus.count),
    .empty        (bus.empty),
    .full         (bus.full),
    .almost_empty (bus.almost_empty),
    .almost_full  (bus.almost_full),
    .overflow     (bus.overflow),
    .underflow    (bus.underflow)
  );

  // Storage write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[w_ptr_s] <= bus.w_data;
    end
  end

  assign bus.r_data = mem_q[r_ptr_s];

endmodule

// File: tb/tb_fifo_flags.sv
// Directed-vector and queue-model bench for fifo_flags at DEPTH=4, AF=3, AE=1.
module tb_fifo_flags;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int AF = 3;
  localparam int AE = 1;
  localparam int DEPTH = 4;

  typedef struct {
    bit       rd;
    bit       wr;
    bit       clr;
    bit [7:0] wdata;
    bit       chk_rdata;
    bit [7:0] e_rdata;
    int       e_count;
    bit       e_empty;
    bit       e_full;
    bit       e_ae;
    bit       e_af;
    bit       e_ovf;
    bit       e_udf;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  vec_t vecs[18];
  logic [7:0] model_q[$];
  bit   m_ovf, m_udf;

  fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_flags #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit chk_rd, input logic [7:0] e_rd,
                         input int e_cnt, input bit e_emp, input bit e_ful, input bit e_ae,
                         input bit e_af, input bit e_ovf, input bit e_udf);
    if (chk_rd) chk({tag, " r_data"}, 32'(bus.r_data), 32'(e_rd));
    chk({tag, " count"},        32'(bus.count),        e_cnt);
    chk({tag, " empty"},        32'(bus.empty),        32'(e_emp));
    chk({tag, " full"},         32'(bus.full),         32'(e_ful));
    chk({tag, " almost_empty"}, 32'(bus.almost_empty), 32'(e_ae));
    chk({tag, " almost_full"},  32'(bus.almost_full),  32'(e_af));
    chk({tag, " overflow"},     32'(bus.overflow),     32'(e_ovf));
    chk({tag, " underflow"},    32'(bus.underflow),    32'(e_udf));
  endtask

  task automatic drive_step(input bit rd, input bit wr, input bit clr, input logic [7:0] wd);
    @(negedge clk);
    bus.rd      = rd;
    bus.wr      = wr;
    bus.clr_err = clr;
    bus.w_data  = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
    bus.clr_err = 1'b0;
    bus.w_data  = 8'h00;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    idle_inputs();

    //        rd    wr    clr   wdata  chk   rdata  cnt  emp  ful  ae   af   ovf  udf
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h0A, 1'b1, 8'h0A, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h0B, 1'b1, 8'h0A, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h0C, 1'b1, 8'h0A, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h0D, 1'b1, 8'h0A, 4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'hEE, 1'b1, 8'h0A, 4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'hEF, 1'b1, 8'h0A, 4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h0A, 4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h0E, 1'b1, 8'h0B, 4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h0C, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h0D, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h0E, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 8'h0F, 1'b1, 8'h0F, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state, sampled while reset is held.
    #12;
    chk_all("reset", 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive_step(vecs[i].rd, vecs[i].wr, vecs[i].clr, vecs[i].wdata);
      chk_all($sformatf("vec%0d", i), vecs[i].chk_rdata, vecs[i].e_rdata, vecs[i].e_count,
              vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ae, vecs[i].e_af,
              vecs[i].e_ovf, vecs[i].e_udf);
    end

    // Asynchronous reset between edges, with three words queued and an error set.
    drive_step(1'b0, 1'b1, 1'b0, 8'h21);
    drive_step(1'b0, 1'b1, 1'b0, 8'h22);
    drive_step(1'b1, 1'b1, 1'b0, 8'h23);
    drive_step(1'b1, 1'b0, 1'b0, 8'h00);
    drive_step(1'b1, 1'b0, 1'b0, 8'h00);
    drive_step(1'b1, 1'b0, 1'b0, 8'h00);
    drive_step(1'b0, 1'b1, 1'b0, 8'h31);
    drive_step(1'b0, 1'b1, 1'b0, 8'h32);
    drive_step(1'b0, 1'b1, 1'b0, 8'h33);
    idle_inputs();
    chk_all("pre_arst", 1'b1, 8'h31, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("arst", 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive_step(1'b0, 1'b1, 1'b0, 8'h11);
    chk_all("post_arst", 1'b1, 8'h11, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Random traffic against a queue model, from a fresh reset.
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      bit r, w, cl, m_full, m_empty, acc_wr, acc_rd;
      logic [7:0] d;
      r  = ($urandom_range(0, 99) < 50);
      w  = ($urandom_range(0, 99) < 55);
      cl = ($urandom_range(0, 99) < 8);
      d  = 8'($urandom());
      m_full  = (model_q.size() == DEPTH);
      m_empty = (model_q.size() == 0);
      acc_wr  = w && (!m_full || r);
      acc_rd  = r && !m_empty;
      if (w && !acc_wr) m_ovf = 1'b1;
      else if (cl)      m_ovf = 1'b0;
      if (r && m_empty) m_udf = 1'b1;
      else if (cl)      m_udf = 1'b0;
      if (acc_rd) void'(model_q.pop_front());
      if (acc_wr) model_q.push_back(d);
      drive_step(r, w, cl, d);
      chk_all($sformatf("rnd%0d", c), (model_q.size() != 0),
              (model_q.size() != 0) ? model_q[0] : 8'h00, model_q.size(),
              (model_q.size() == 0), (model_q.size() == DEPTH),
              (model_q.size() <= AE), (model_q.size() >= AF), m_ovf, m_udf);
    end

    idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
